// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq -- time-multiplexed AES SubBytes engine.
//
// SBOX_LANES shared sbox instances walk the 16 state bytes in groups of
// SBOX_LANES. The whole state takes NUM_STEPS = 16/SBOX_LANES cycles. The
// input and output use a valid/ready handshake.
//
// Optional feature macro: SUB_BYTES_SEQ_OVERLAP_EN
//   When it is defined, a new state can be accepted in the same cycle as the
//   output handshake. The engine then goes from DONE straight back to RUN.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    engine can accept a state
//   in_state   in   128  AES state, byte 0 in [127:120], byte 15 in [7:0]
//   out_valid  out  1    substituted state available
//   out_ready  in   1    downstream accepts
//   out_state  out  128  substituted state, same layout (zero unless valid)
//   busy       out  1    high in RUN or DONE
// -----------------------------------------------------------------------------

// sbox -- purely combinational AES S-box.
// Computes the GF(2^8) inverse as a^254 and then applies the affine map.
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] INV_EXP = 8'hFE;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      acc = b[i] ? (acc ^ x) : acc;
      x   = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    // Square-and-multiply for a^254. The result for 0 is 0, which is the value AES needs.
    for (int i = 0; i < 8; i++) begin
      r = INV_EXP[i] ? gf_mul(r, p) : r;
      p = gf_mul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Combinational substitution.
  always_comb begin
    o_byte = sbox_f(i_byte);
  end

endmodule

module sub_bytes_seq #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / SBOX_LANES;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STEPS - 1);

  generate
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [127:0]       r_work;
  logic [127:0]       w_work_nxt;
  logic [7:0]         w_lane_in  [SBOX_LANES];
  logic [7:0]         w_lane_out [SBOX_LANES];

  // Lane operand select. Only the step counter drives it, so there is no path from in_state.
  always_comb begin
    for (int i = 0; i < SBOX_LANES; i++) begin
      w_lane_in[i] = r_work[8 * (15 - ((int'(r_cnt) * SBOX_LANES + i) & 15)) +: 8];
    end
  end

  generate
    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
      sbox u_sbox (
        .i_byte (w_lane_in[g]),
        .o_byte (w_lane_out[g])
      );
    end
  endgenerate

  // State, step counter and work register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_work  <= 128'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_work  <= w_work_nxt;
    end
  end

  // Next-state, byte write-back and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_state   = 128'd0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_work_nxt  = in_state;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        for (int i = 0; i < SBOX_LANES; i++) begin
          w_work_nxt[8 * (15 - ((int'(r_cnt) * SBOX_LANES + i) & 15)) +: 8] = w_lane_out[i];
        end
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_state = r_work;
`ifdef SUB_BYTES_SEQ_OVERLAP_EN
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_work_nxt  = in_state;
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
`else
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_work_nxt  = 128'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// Testbench for sub_bytes_seq.
// Three instances are built with 4, 1 and 16 lanes. They share the clock and
// the reset. Expected results come from the standard AES S-box table, which is
// applied byte by byte.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ordy [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         bz   [3];
  logic [127:0] is_  [3];
  logic [127:0] os   [3];
  int           passed = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  sub_bytes_seq #(.SBOX_LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(is_[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]), .busy(bz[0]));
  sub_bytes_seq #(.SBOX_LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(is_[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]), .busy(bz[1]));
  sub_bytes_seq #(.SBOX_LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(is_[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]), .busy(bz[2]));

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX_TAB;
    return t[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = sb(st[127 - 8 * k -: 8]);
    return r;
  endfunction

  function automatic int steps_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int d, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ov[d] !== 1'b1 && n < 64);
  endtask

  // One complete transaction with out_ready high. The instance must start in IDLE.
  task automatic run_one(input int d, input logic [127:0] st, input logic [127:0] exp, input string tag);
    int n;
    iv[d] = 1'b1; is_[d] = st; ordy[d] = 1'b1;
    chk({tag, " in_ready"}, 128'(ir[d]), 128'd1);
    tick();
    iv[d] = 1'b0; is_[d] = rnd128();
    chk({tag, " run busy"}, {126'd0, bz[d], ov[d]}, 128'd2);
    wait_ov(d, n);
    chk({tag, " latency"}, 128'(n), 128'(steps_of(d)));
    chk({tag, " out_state"}, os[d], exp);
    tick();
    chk({tag, " idle after"}, {125'd0, ir[d], ov[d], bz[d]}, 128'd4);
  endtask

  initial begin
    int n;
    int n2;
    logic [127:0] a;
    logic [127:0] b;
    logic bad;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; is_[d] = 128'd0;
    end
    #2;
    chk("reset outs", {ir[0], ov[0], bz[0], os[0][124:0]}, {3'b100, 125'd0});
    #20;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Drive instance 0 into DONE and hold it there, then reset it in mid-cycle.
    iv[0] = 1'b1; is_[0] = 128'h000102030405060708090A0B0C0D0E0F; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    wait_ov(0, n);
    chk("pre-reset valid", 128'(ov[0]), 128'd1);
    #3 rst = 1'b1;
    #1;
    chk("async reset outs", {ir[0], ov[0], bz[0]}, 128'd4);
    chk("async reset state", os[0], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("after reset idle", {ir[0], ov[0], bz[0]}, 128'd4);

    // Single known vector (the first S-box row).
    run_one(0, 128'h000102030405060708090A0B0C0D0E0F, 128'h637C777BF26B6FC53001672BFED7AB76, "vec4");

    // Backpressure with in_valid toggling in DONE, which must be ignored.
    iv[0] = 1'b1; is_[0] = {16{8'h53}}; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    wait_ov(0, n);
    chk("bp latency", 128'(n), 128'd4);
    iv[0] = 1'b1; is_[0] = rnd128();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp hold valid", {ov[0], ir[0]}, 128'd2);
      chk("bp hold state", os[0], {16{8'hED}});
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("bp release idle", {ir[0], ov[0], bz[0]}, 128'd4);

    // Sweep the lane counts.
    run_one(1, {16{8'hFF}}, {16{8'h16}}, "lanes1");
    run_one(2, {16{8'hFF}}, {16{8'h16}}, "lanes16");

    // Reset at cnt=2. No output may appear, and the next result must not contain old bytes.
    iv[0] = 1'b1; is_[0] = {16{8'h01}}; ordy[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    chk("midrun reset valid", {ov[0], bz[0]}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ov[0] !== 1'b0) bad = 1'b1;
    end
    chk("no partial output", 128'(bad), 128'd0);
    run_one(0, {16{8'h00}}, {16{8'h63}}, "fresh zero");

    // Random states on every instance.
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 3; d++) begin
        a = rnd128();
        run_one(d, a, ref_sub(a), "random");
      end
    end

    // Two back-to-back states with out_ready held high.
    a = rnd128(); b = rnd128();
    iv[0] = 1'b1; is_[0] = a; ordy[0] = 1'b1;
    tick();
    is_[0] = b;
    wait_ov(0, n);
    chk("b2b first latency", 128'(n), 128'd4);
    chk("b2b first state", os[0], ref_sub(a));
`ifdef SUB_BYTES_SEQ_OVERLAP_EN
    chk("b2b in_ready in done", 128'(ir[0]), 128'd1);
`else
    chk("b2b in_ready in done", 128'(ir[0]), 128'd0);
`endif
    wait_ov(0, n2);
    iv[0] = 1'b0;
`ifdef SUB_BYTES_SEQ_OVERLAP_EN
    chk("b2b spacing", 128'(n2), 128'd5);
`else
    chk("b2b spacing", 128'(n2), 128'd6);
`endif
    chk("b2b second state", os[0], ref_sub(b));
    tick();
    chk("b2b idle", {ir[0], ov[0], bz[0]}, 128'd4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
